// File: rtl/tl_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : tl_mon_pkg
// Brief  : Light codes, error causes, FSM states and the lock-phase decoder
//          shared by the traffic-light monitor.
// Rev    : 1.0  initial release
// ============================================================================
package tl_mon_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_SHORT   = 2'b11;

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Returns {hit, phase}. Yellow is shared by two phases per street, so only
  // green and left patterns identify a phase unambiguously.
  function automatic logic [3:0] lock_phase(input logic [1:0] la, input logic [1:0] lb);
    logic [3:0] r;
    r = 4'b0000;
    if (la != RED && lb == RED) begin
      if (la == GREEN) r = 4'b1000;
      if (la == LEFT)  r = 4'b1010;
    end else if (la == RED && lb != RED) begin
      if (lb == GREEN) r = 4'b1100;
      if (lb == LEFT)  r = 4'b1110;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_light_monitor_if.sv
`default_nettype none
// ============================================================================
// Module : tl_light_monitor_if
// Brief  : Light inputs and checker outputs of the traffic-light monitor.
//          TL_MON_STATS_EN adds the round_cnt / err_cnt statistics signals.
// Rev    : 1.0  initial release
// ============================================================================
interface tl_light_monitor_if #(
  parameter int DWELL_W = 8
) ();

  logic [1:0]         La;
  logic [1:0]         Lb;
  logic [2:0]         q_est;
  logic               locked;
  logic [DWELL_W-1:0] dwell;
  logic               err;
  logic [1:0]         err_code;
  logic               err_sticky;
`ifdef TL_MON_STATS_EN
  logic [15:0]        round_cnt;
  logic [7:0]         err_cnt;
`endif

  modport master (
    output La, Lb,
    input  q_est, locked, dwell, err, err_code, err_sticky
`ifdef TL_MON_STATS_EN
    , input round_cnt, err_cnt
`endif
  );

  modport slave (
    input  La, Lb,
    output q_est, locked, dwell, err, err_code, err_sticky
`ifdef TL_MON_STATS_EN
    , output round_cnt, err_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/tl_expect_enc.sv
`default_nettype none
// ============================================================================
// Module : tl_expect_enc
// Brief  : Combinational controller phase -> expected {La,Lb} light pattern.
// Rev    : 1.0  initial release
// ============================================================================
module tl_expect_enc
  import tl_mon_pkg::*;
(
  input  logic [2:0] phase,
  output logic [3:0] pattern
);

  always_comb begin
    pattern = {RED, RED};
    case (phase)
      3'd0:    pattern = {GREEN,  RED};
      3'd1:    pattern = {YELLOW, RED};
      3'd2:    pattern = {LEFT,   RED};
      3'd3:    pattern = {YELLOW, RED};
      3'd4:    pattern = {RED,    GREEN};
      3'd5:    pattern = {RED,    YELLOW};
      3'd6:    pattern = {RED,    LEFT};
      3'd7:    pattern = {RED,    YELLOW};
      default: pattern = {RED,    RED};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tl_light_monitor.sv
`default_nettype none
// ============================================================================
// Module : tl_light_monitor
// Brief  : Reconstructs the traffic-light controller phase from La/Lb and
//          flags illegal, out-of-order and too-short phases.
//          Define TL_MON_STATS_EN to add round_cnt / err_cnt statistics.
// Rev    : 1.0  initial release
// ============================================================================
module tl_light_monitor
  import tl_mon_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int MIN_DWELL = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  tl_light_monitor_if.slave   mon
);

  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_e             state_q, state_d;
  logic [2:0]         q_est_q, q_est_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               err_sticky_q, err_sticky_d;
  logic               armed_q, armed_d;

  logic [3:0] pat;
  logic [3:0] exp_cur;
  logic [3:0] exp_nxt;
  logic [2:0] q_nxt;
  logic [3:0] lock_info;
  logic       legal;
  logic       try_lock;
  logic       wrap_adv;

  assign pat       = {mon.La, mon.Lb};
  assign q_nxt     = q_est_q + 3'd1;
  assign legal     = (mon.La == RED) != (mon.Lb == RED);
  assign lock_info = lock_phase(mon.La, mon.Lb);

  tl_expect_enc u_enc_cur (.phase(q_est_q), .pattern(exp_cur));
  tl_expect_enc u_enc_nxt (.phase(q_nxt),   .pattern(exp_nxt));

  always_comb begin
    state_d      = state_q;
    q_est_d      = q_est_q;
    dwell_d      = dwell_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    err_sticky_d = err_sticky_q;
    armed_d      = armed_q;
    try_lock     = 1'b0;
    wrap_adv     = 1'b0;

    case (state_q)
      SYNC: begin
        if (!legal) begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end else begin
          try_lock = 1'b1;
        end
      end
      LOCKED: begin
        if (!legal) begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
          state_d    = SYNC;
          dwell_d    = '0;
        end else if (pat == exp_cur) begin
          if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DWELL_ONE;
        end else if (pat == exp_nxt) begin
          q_est_d  = q_nxt;
          dwell_d  = DWELL_ONE;
          armed_d  = 1'b1;
          wrap_adv = (q_est_q == 3'd7);
          if (armed_q && dwell_q < DWELL_MIN) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
          end
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_ORDER;
          state_d    = SYNC;
          dwell_d    = '0;
          try_lock   = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    // A fresh lock never checks the dwell of its first phase.
    if (try_lock && lock_info[3]) begin
      state_d = LOCKED;
      q_est_d = lock_info[2:0];
      dwell_d = DWELL_ONE;
      armed_d = 1'b0;
    end

    if (err_d) err_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SYNC;
      q_est_q      <= 3'd0;
      dwell_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_est_q      <= q_est_d;
      dwell_q      <= dwell_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
      armed_q      <= armed_d;
    end
  end

  assign mon.q_est      = q_est_q;
  assign mon.locked     = (state_q == LOCKED);
  assign mon.dwell      = dwell_q;
  assign mon.err        = err_q;
  assign mon.err_code   = err_code_q;
  assign mon.err_sticky = err_sticky_q;

`ifdef TL_MON_STATS_EN
  logic [15:0] round_cnt_q, round_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    round_cnt_d = round_cnt_q + {15'd0, wrap_adv};
    err_cnt_d   = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      round_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      round_cnt_q <= round_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mon.round_cnt = round_cnt_q;
  assign mon.err_cnt   = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = wrap_adv;
`endif

endmodule
`default_nettype wire

// File: doc/tl_light_monitor.md
Name: tl_light_monitor

Overview:
- Receiving end of the traffic-light controller's light outputs. Samples the La/Lb light codes every clock and reconstructs the controller phase Q[2:0].
- Checks that phases follow the legal 8-phase sequence and dwell at least MIN_DWELL cycles. Flags illegal or out-of-order light patterns.
- Sits beside the controller as an on-chip checker. Also used as a bench scoreboard for the structural controller.

Parameters:
- DWELL_W, 8, width of dwell counter (saturating).
- MIN_DWELL, 2, minimum cycles a phase must be shown before advancing; range 1..2^DWELL_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- La  input  2  street A light code (00 green, 01 yellow, 10 left, 11 red)
- Lb  input  2  street B light code, same encoding
- q_est  output  3  reconstructed controller phase
- locked  output  1  q_est valid
- dwell  output  DWELL_W  cycles current phase has been shown, 1 on entry, saturating
- err  output  1  one-cycle error pulse
- err_code  output  2  cause of last error: 00 none, 01 illegal pattern, 10 out-of-order, 11 dwell too short
- err_sticky  output  1  set on any err, cleared only by reset

Behaviour:
- Phase to pattern map {La,Lb} (fixed):
  - 000 -> 00,11; 001 -> 01,11; 010 -> 10,11; 011 -> 01,11
  - 100 -> 11,00; 101 -> 11,01; 110 -> 11,10; 111 -> 11,01
- Sequence is 000 -> 001 -> ... -> 111 -> 000 (wrap).
- Legal patterns: exactly one street at 11, the other at 00, 01 or 10. All others are illegal (e.g. 11,11 or 00,00).
- All outputs are registered and reflect the pattern sampled at the same rising edge; latency is 1 cycle from pattern to outputs.
- Reset (reset_n low at an edge), also mid-operation:
  - FSM goes to SYNC; q_est=000, locked=0, dwell=0, err=0, err_code=00, err_sticky=0.
- FSM with two states, SYNC and LOCKED:
  - SYNC, illegal pattern: err=1, code 01; stay in SYNC.
  - SYNC, yellow pattern (01,11 or 11,01): the phase is ambiguous (001/011, 101/111). Stay in SYNC, no error.
  - SYNC, green or left pattern: lock to the unique phase. locked=1, dwell=1, short-check disarmed for this first phase.
  - LOCKED, pattern equals expected(q_est): hold; dwell increments, saturating at 2^DWELL_W-1.
  - LOCKED, pattern equals expected(q_est+1 mod 8): advance; q_est+1, dwell=1.
    - If armed and the old dwell < MIN_DWELL: err=1, code 11, remain LOCKED.
    - Short-check is armed after the first advance.
  - LOCKED, illegal pattern: err=1, code 01. Go to SYNC, locked=0, dwell=0, q_est holds last value.
  - LOCKED, legal but neither hold nor advance (skip, reverse): err=1, code 10. Go to SYNC, then lock on this same cycle if the pattern is unambiguous (same rules as SYNC).
- Error priority: illegal > out-of-order > short. At most one err pulse per cycle.
- err_code holds its last cause until the next error or reset.

Optional Feature:
- TL_MON_STATS_EN defined: adds output round_cnt (16 bits).
  - Increments on each legal 111 -> 000 advance while LOCKED and wraps at 2^16. Reset to 0.
  - Also adds err_cnt (8 bits, saturating), incremented on every err pulse.
- Not defined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Package tl_mon_pkg holds:
  - light code constants: GREEN=2'b00, YELLOW=2'b01, LEFT=2'b10, RED=2'b11
  - err_code constants
  - FSM state encoding: SYNC, LOCKED
- One sub-module, tl_expect_enc: combinational phase -> {La,Lb} expected pattern.
  - Instanced twice, for q_est and q_est+1.

Test Plan:
- Reset, then drive 00,11 for 3 cycles -> locked=1 after first edge, q_est=000, dwell 1,2,3, err=0.
- Full legal round, each phase 2 cycles from 000 -> q_est steps 000..111..000, never err. With TL_MON_STATS_EN, round_cnt=1.
- From locked q_est=000, drive 10,11 (skip 001) -> err pulse, err_code=10, err_sticky=1. Relocks to q_est=010 the same cycle.
- MIN_DWELL=2, armed: phase 001 shown for 1 cycle then 10,11 -> err, code 11, q_est=010, locked stays 1.
- Drive 11,11 while locked -> err, code 01, locked=0. Then 01,11 -> still unlocked, no err. Then 10,11 -> locked, q_est=010.
- Assert reset_n=0 mid-round with err_sticky=1 -> next edge all outputs at reset values, FSM in SYNC.
